// File: rtl/fft_sequencer_if.sv
// Control/status and memory-address bundle of the radix-2 FFT sequencer.
// cycle_count is present only when FFT_SEQ_CYCLE_CNT_EN is defined.
interface fft_sequencer_if #(
    parameter int LOG2N = 4
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [LOG2N-1:0] stage;
`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [15:0]      cycle_count;
`endif

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
`ifdef FFT_SEQ_CYCLE_CNT_EN
        , output cycle_count
`endif
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
`ifdef FFT_SEQ_CYCLE_CNT_EN
        , input cycle_count
`endif
    );
endinterface

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIT FFT address/strobe sequencer with stage drain bubbles.
// Optional busy-cycle counter enabled by defining FFT_SEQ_CYCLE_CNT_EN.
module fft_sequencer #(
    parameter int LOG2N    = 4,
    parameter int MEM_LAT  = 1,
    parameter int BFLY_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    fft_sequencer_if.master bus
);
    localparam int L  = MEM_LAT + BFLY_LAT;
    localparam int JW = LOG2N - 1;
    localparam int CW = $clog2(L + 1);
    localparam logic [JW-1:0]    J_LAST = '1;
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [CW-1:0]    D_LAST = CW'(L - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [JW-1:0]    tw;
    } addr_t;

    function automatic addr_t bfly_addr(input logic [LOG2N-1:0] s, input logic [JW-1:0] j);
        addr_t            r;
        logic [LOG2N-1:0] jw;
        logic [LOG2N-1:0] half;
        logic [LOG2N-1:0] pos;
        jw   = {1'b0, j};
        half = LOG2N'(1) << s;
        pos  = jw & (half - 1'b1);
        r.a  = ((jw >> s) << (s + 1'b1)) | pos;
        r.b  = r.a + half;
        r.tw = JW'(pos << (S_LAST - s));
        return r;
    endfunction

    state_t           r_state;
    logic [LOG2N-1:0] r_stage;
    logic [JW-1:0]    r_j;
    logic [CW-1:0]    r_drain;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    addr_t            r_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_j     <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= ISSUE;
                        r_stage <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_rd    <= bfly_addr('0, '0);
                    end
                end
                ISSUE: begin
                    if (r_j == J_LAST) begin
                        r_state <= DRAIN;
                        r_rd_en <= 1'b0;
                        r_drain <= '0;
                    end else begin
                        r_j  <= r_j + 1'b1;
                        r_rd <= bfly_addr(r_stage, r_j + 1'b1);
                    end
                end
                DRAIN: begin
                    // Bubble until the stage's last write has left the pipeline.
                    if (r_drain != D_LAST) begin
                        r_drain <= r_drain + 1'b1;
                    end else if (r_stage != S_LAST) begin
                        r_state <= ISSUE;
                        r_stage <= r_stage + 1'b1;
                        r_j     <= '0;
                        r_rd_en <= 1'b1;
                        r_rd    <= bfly_addr(r_stage + 1'b1, '0);
                    end else begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write-back pipeline: entry p0 is one cycle after the read, entry L-1 is the write.
    logic             r_wr_vld_p [L];
    logic [LOG2N-1:0] r_wr_a_p   [L];
    logic [LOG2N-1:0] r_wr_b_p   [L];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                r_wr_vld_p[i] <= 1'b0;
                r_wr_a_p[i]   <= '0;
                r_wr_b_p[i]   <= '0;
            end
        end else begin
            r_wr_vld_p[0] <= r_rd_en;
            r_wr_a_p[0]   <= r_rd.a;
            r_wr_b_p[0]   <= r_rd.b;
            for (int i = 1; i < L; i++) begin
                r_wr_vld_p[i] <= r_wr_vld_p[i-1];
                r_wr_a_p[i]   <= r_wr_a_p[i-1];
                r_wr_b_p[i]   <= r_wr_b_p[i-1];
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = r_rd.a;
    assign bus.rd_addr_b = r_rd.b;
    assign bus.tw_addr   = r_rd.tw;
    assign bus.stage     = r_stage;
    assign bus.wr_en     = r_wr_vld_p[L-1];
    assign bus.wr_addr_a = r_wr_a_p[L-1];
    assign bus.wr_addr_b = r_wr_b_p[L-1];

`ifdef FFT_SEQ_CYCLE_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_cycle_count <= '0;
        end else if (r_busy) begin
            r_cycle_count <= sat_inc16(r_cycle_count);
        end
    end

    assign bus.cycle_count = r_cycle_count;
`endif
endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
In-place radix-2 DIT FFT controller that sequences the butterfly datapath over a dual-read/dual-write sample memory and a twiddle ROM. On start, it walks all LOG2N stages × N/2 butterflies. Per butterfly it issues read addresses and a twiddle address, then issues the matching write-back after a fixed pipeline delay. It inserts drain bubbles between stages so a stage never reads a location before the previous stage has written it. Samples are expected in bit-reversed order before start; output is natural order.

Parameters:
LOG2N, 4, log2 of FFT size N (N=16 by default); legal range 2..10
MEM_LAT, 1, read latency in cycles of the sample RAM and twiddle ROM, from address to data
BFLY_LAT, 2, butterfly latency in cycles, from inputs valid to Y outputs valid

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run one FFT; honoured only in IDLE
busy  out  1  high from the first read issue through the last write
done  out  1  single-cycle pulse, the cycle after the final write
rd_en  out  1  read strobe for both RAM ports and the twiddle ROM
rd_addr_a  out  LOG2N  RAM address of butterfly input A
rd_addr_b  out  LOG2N  RAM address of butterfly input B
tw_addr  out  LOG2N-1  twiddle ROM index k, selecting W_N^k
wr_en  out  1  write strobe for both RAM write ports
wr_addr_a  out  LOG2N  write address for Ya
wr_addr_b  out  LOG2N  write address for Yb
stage  out  LOG2N-bit  current stage index; wide enough for 0..LOG2N-1

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, rd_en=0, wr_en=0; all addresses=0; stage=0. FSM goes to IDLE.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: on start=1, clear counters, go to ISSUE.
  - ISSUE: once per cycle, assert rd_en and drive the addresses for butterfly j of stage s, then increment j.
    - After j=N/2-1, go to DRAIN.
  - DRAIN: rd_en=0; wait exactly L=MEM_LAT+BFLY_LAT cycles.
    - Then, if s<LOG2N-1, set s=s+1, j=0, and go to ISSUE.
    - Otherwise go to FINISH.
  - FINISH: pulse done for one cycle, drop busy, return to IDLE.
- Address arithmetic, with half=1<<s and pos=j&(half-1):
  - rd_addr_a = ((j>>s)<<(s+1)) | pos
  - rd_addr_b = rd_addr_a + half
  - tw_addr = pos<<(LOG2N-1-s)
- Write-back uses a shift pipeline of depth L that carries valid, addr_a and addr_b.
  - wr_en and wr_addr_a/b for a read issued in cycle t appear in cycle t+L.
- Timing:
  - start sampled in cycle 0 gives the first rd_en in cycle 1. busy rises in cycle 1.
  - Stage period is N/2+L cycles.
  - The last write occurs in cycle LOG2N*(N/2+L); done pulses in the following cycle.
- start while not in IDLE is ignored; there is no queueing.
- start asserted in the same cycle as done: ignored, because the FSM is in FINISH. It is accepted if held one more cycle.
- reset mid-run: abort immediately. Write-pipeline valids are cleared, so no write occurs after reset. Memory contents are undefined.
- The next stage's first read never coincides with the previous stage's last write. The RAM read-during-write behaviour is therefore irrelevant.

Optional Feature:
FFT_SEQ_CYCLE_CNT_EN.
- Defined: adds output port cycle_count, 16 bits.
  - Cleared on reset and on an accepted start.
  - Increments every cycle while busy=1, saturating at 16'hFFFF.
  - Holds its value after done until the next accepted start.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Defaults (N=16, L=3); start in cycle 0 -> rd_en in cycles 1..8, 12..19, 23..30 and 34..41; wr_en 3 cycles after each read; last write in cycle 44; done=1 only in cycle 45; busy=1 in cycles 1..44.
- Stage 2, j=5 -> rd_addr_a=9, rd_addr_b=13, tw_addr=2. Stage 0, j=7 -> addresses 14/15, tw_addr=0. Stage 3, j=7 -> addresses 7/15, tw_addr=7.
- start pulsed in cycle 20 mid-run -> ignored; the sequence and done cycle are unchanged from the first test.
- reset asserted in cycle 15 -> from cycle 16: busy=0, rd_en=0, wr_en=0, no done; a new start afterwards yields a full, clean run.
- Parameter sweep LOG2N=3, MEM_LAT=2, BFLY_LAT=1 -> stage period 7; done in cycle 22. Golden-model check: the butterfly model plus RAM matches a reference FFT of an impulse input (all outputs equal x[0]).
- FFT_SEQ_CYCLE_CNT_EN defined, defaults -> cycle_count=44 after done, held for 10 idle cycles, then 0 in the cycle after the next accepted start.
